stereo_channel_mixer: RTL and testbench

//   Parametrised N-channel stereo mixer between music_player's per-voice outputs and the codec.

---
 rtl/stereo_channel_mixer.sv | 196 +++++++++++++++++++
 tb/tb_stereo_channel_mixer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_channel_mixer.sv
// Serial N-channel stereo mixer: per-channel pan, master attenuation, global L/R swap, saturation.
// Optional peak meter enabled by defining MIXER_PEAK_METER_EN.
module stereo_channel_mixer #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned CH_IDX_W   = 2,
  parameter int unsigned ATT_MAX    = 7,
  parameter int unsigned PEAK_DECAY = 1024
) (
  input  logic                     clk_100,
  input  logic                     reset_n,
  input  logic                     in_ready,
  input  logic [N_CH*SAMPLE_W-1:0] samples_in,
  input  logic [CH_IDX_W-1:0]      sel_ch,
  input  logic                     pan_next,
  input  logic                     att_next,
  input  logic                     swap,
  output logic [SAMPLE_W-1:0]      out_l,
  output logic [SAMPLE_W-1:0]      out_r,
  output logic                     out_ready,
  output logic                     busy,
  output logic [7:0]               overrun_cnt,
  output logic [2*N_CH-1:0]        pan_state,
  output logic [3:0]               peak_l,
  output logic [3:0]               peak_r
);

  localparam int unsigned ACC_W = SAMPLE_W + CH_IDX_W + 1;
  localparam int unsigned ATT_W = (ATT_MAX < 2) ? 1 : $clog2(ATT_MAX + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(SAMPLE_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  if (N_CH < 1 || SAMPLE_W < 5 || PEAK_DECAY < 1 || (2**CH_IDX_W) < N_CH) begin : g_param_check
    $error("stereo_channel_mixer: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, DONE} state_t;
  state_t state, state_nx;

  logic [2*N_CH-1:0]        pan_q;
  logic [ATT_W-1:0]         att_q;
  logic                     swap_q;
  logic [N_CH*SAMPLE_W-1:0] snap_s;
  logic [2*N_CH-1:0]        snap_pan;
  logic [ATT_W-1:0]         snap_att;
  logic                     snap_swap;
  logic [CH_IDX_W-1:0]      idx;
  logic signed [ACC_W-1:0]  acc_l, acc_r;

  logic [SAMPLE_W-1:0]      cur;
  logic [1:0]               cur_pan;
  logic signed [ACC_W-1:0]  cur_ext;
  logic signed [ACC_W-1:0]  sh_l, sh_r;
  logic [SAMPLE_W-1:0]      sat_l, sat_r;

  function automatic logic [SAMPLE_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    else                  return v[SAMPLE_W-1:0];
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_ready) state_nx = ACCUM;
      ACCUM:   if (idx == CH_IDX_W'(N_CH - 1)) state_nx = SAT;
      SAT:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur     = '0;
    cur_pan = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (idx == CH_IDX_W'(i)) begin
        cur     = snap_s[i*SAMPLE_W +: SAMPLE_W];
        cur_pan = snap_pan[2*i +: 2];
      end
    end
    cur_ext = {{(ACC_W-SAMPLE_W){cur[SAMPLE_W-1]}}, cur};
    sh_l    = acc_l >>> snap_att;
    sh_r    = acc_r >>> snap_att;
    sat_l   = clamp(sh_l);
    sat_r   = clamp(sh_r);
  end

  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      state       <= IDLE;
      pan_q       <= '0;
      att_q       <= '0;
      swap_q      <= 1'b0;
      snap_s      <= '0;
      snap_pan    <= '0;
      snap_att    <= '0;
      snap_swap   <= 1'b0;
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      out_l       <= '0;
      out_r       <= '0;
      overrun_cnt <= '0;
    end else begin
      state <= state_nx;
      // Pan codes advance BOTH->LEFT->RIGHT->MUTE by plain 2-bit increment
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (pan_next && sel_ch == CH_IDX_W'(i))
          pan_q[2*i +: 2] <= pan_q[2*i +: 2] + 2'd1;
      end
      if (att_next)
        att_q <= (att_q == ATT_W'(ATT_MAX)) ? '0 : att_q + 1'b1;
      if (swap)
        swap_q <= ~swap_q;
      if (in_ready && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (in_ready) begin
            snap_s    <= samples_in;
            snap_pan  <= pan_q;
            snap_att  <= att_q;
            snap_swap <= swap_q;
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          if (!cur_pan[1]) acc_l <= acc_l + cur_ext;
          if (!cur_pan[0]) acc_r <= acc_r + cur_ext;
          idx <= idx + 1'b1;
        end
        SAT: begin
          out_l <= snap_swap ? sat_r : sat_l;
          out_r <= snap_swap ? sat_l : sat_r;
        end
        default: ;
      endcase
    end
  end

  assign out_ready = (state == DONE);
  assign busy      = (state != IDLE);
  assign pan_state = pan_q;

`ifdef MIXER_PEAK_METER_EN
  localparam int unsigned DEC_W = (PEAK_DECAY < 2) ? 1 : $clog2(PEAK_DECAY);

  logic [3:0]       pk_q [2];
  logic [DEC_W-1:0] dc_q [2];
  logic [3:0]       lv   [2];

  function automatic logic [3:0] level(input logic [SAMPLE_W-1:0] v);
    logic [SAMPLE_W-1:0] a;
    if (v == {1'b1, {(SAMPLE_W-1){1'b0}}}) a = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (v[SAMPLE_W-1])                a = -v;
    else                                   a = v;
    return a[SAMPLE_W-2 -: 4];
  endfunction

  assign lv[0] = level(out_l);
  assign lv[1] = level(out_r);

  // Decay counter restarts whenever a new peak is captured
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < 2; s++) begin
        pk_q[s] <= '0;
        dc_q[s] <= '0;
      end
    end else if (state == DONE) begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (lv[s] > pk_q[s]) begin
          pk_q[s] <= lv[s];
          dc_q[s] <= '0;
        end else if (dc_q[s] == DEC_W'(PEAK_DECAY - 1)) begin
          dc_q[s] <= '0;
          if (pk_q[s] != 4'd0) pk_q[s] <= pk_q[s] - 4'd1;
        end else begin
          dc_q[s] <= dc_q[s] + 1'b1;
        end
      end
    end
  end

  assign peak_l = pk_q[0];
  assign peak_r = pk_q[1];
`else
  assign peak_l = '0;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_stereo_channel_mixer.sv
// Randomised self-checking bench for stereo_channel_mixer against a behavioural frame model.
module tb_stereo_channel_mixer;

  localparam int NCH = 4;
  localparam int DECAY = 4;

  logic        clk_100 = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_ready = 1'b0;
  logic [63:0] samples_in = '0;
  logic [1:0]  sel_ch = '0;
  logic        pan_next = 1'b0;
  logic        att_next = 1'b0;
  logic        swap = 1'b0;
  logic [15:0] out_l, out_r;
  logic        out_ready, busy;
  logic [7:0]  overrun_cnt;
  logic [7:0]  pan_state;
  logic [3:0]  peak_l, peak_r;

  int total = 0;
  int bad = 0;

  int m_pan [NCH];
  int m_att;
  bit m_swap;
  int m_ovr;
  int m_pk [2];
  int m_dc [2];

  stereo_channel_mixer #(
    .N_CH(4), .SAMPLE_W(16), .CH_IDX_W(2), .ATT_MAX(7), .PEAK_DECAY(DECAY)
  ) dut (
    .clk_100(clk_100), .reset_n(reset_n), .in_ready(in_ready), .samples_in(samples_in),
    .sel_ch(sel_ch), .pan_next(pan_next), .att_next(att_next), .swap(swap),
    .out_l(out_l), .out_r(out_r), .out_ready(out_ready), .busy(busy),
    .overrun_cnt(overrun_cnt), .pan_state(pan_state), .peak_l(peak_l), .peak_r(peak_r)
  );

  always #5 clk_100 = ~clk_100;

  task automatic tick;
    @(posedge clk_100);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NCH; i++) m_pan[i] = 0;
    m_att = 0; m_swap = 0; m_ovr = 0;
    for (int s = 0; s < 2; s++) begin m_pk[s] = 0; m_dc[s] = 0; end
  endtask

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Expected stereo result of one frame using the current live control state
  task automatic model_frame(input logic [63:0] s, output int el, output int er);
    int al, ar, v, t;
    al = 0; ar = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      v = int'($signed(s[ch*16 +: 16]));
      if (m_pan[ch] == 0 || m_pan[ch] == 1) al += v;
      if (m_pan[ch] == 0 || m_pan[ch] == 2) ar += v;
    end
    al = clamp16(al >>> m_att);
    ar = clamp16(ar >>> m_att);
    if (m_swap) begin t = al; al = ar; ar = t; end
    el = al; er = ar;
  endtask

  function automatic int level_of(int v);
    int a;
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    return (a / 2048) % 16;
  endfunction

  task automatic model_peak(input int el, input int er);
`ifdef MIXER_PEAK_METER_EN
    int lv [2];
    lv[0] = level_of(el); lv[1] = level_of(er);
    for (int s = 0; s < 2; s++) begin
      if (lv[s] > m_pk[s]) begin
        m_pk[s] = lv[s]; m_dc[s] = 0;
      end else begin
        m_dc[s]++;
        if (m_dc[s] == DECAY) begin
          m_dc[s] = 0;
          if (m_pk[s] > 0) m_pk[s]--;
        end
      end
    end
`endif
  endtask

  function automatic logic [7:0] model_pan_vec();
    logic [7:0] p;
    for (int i = 0; i < NCH; i++) p[2*i +: 2] = 2'(m_pan[i]);
    return p;
  endfunction

  task automatic apply_reset;
    reset_n = 0; in_ready = 0; pan_next = 0; att_next = 0; swap = 0;
    tick; tick;
    reset_n = 1;
    model_reset();
  endtask

  task automatic pulse_pan(input int ch);
    sel_ch = 2'(ch); pan_next = 1; tick; pan_next = 0;
    m_pan[ch] = (m_pan[ch] + 1) % 4;
  endtask

  task automatic pulse_att;
    att_next = 1; tick; att_next = 0;
    m_att = (m_att == 7) ? 0 : m_att + 1;
  endtask

  task automatic pulse_swap;
    swap = 1; tick; swap = 0;
    m_swap = ~m_swap;
  endtask

  // One frame: checks latency, busy, outputs, strobe width, pan_state and peaks
  task automatic run_frame(input logic [63:0] s, input bit mid, input bit same,
                           output logic [15:0] gl, output logic [15:0] gr);
    int el, er, n;
    model_frame(s, el, er);
    samples_in = s; in_ready = 1;
    if (same) begin sel_ch = 0; pan_next = 1; att_next = 1; swap = 1; end
    tick;
    in_ready = 0; pan_next = 0; att_next = 0; swap = 0;
    if (same) begin
      m_pan[0] = (m_pan[0] + 1) % 4;
      m_att = (m_att == 7) ? 0 : m_att + 1;
      m_swap = ~m_swap;
    end
    n = 0;
    while (out_ready !== 1'b1 && n < 20) begin
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid: got %b want 1 (n=%0d)", busy, n); end
      if (mid && n == 1) begin
        att_next = 1; swap = 1;
        m_att = (m_att == 7) ? 0 : m_att + 1;
        m_swap = ~m_swap;
      end else begin
        att_next = 0; swap = 0;
      end
      tick; n++;
    end
    att_next = 0; swap = 0;
    total++;
    if (n != NCH + 1) begin bad++; $display("FAIL latency: got %0d want %0d", n, NCH + 1); end
    gl = out_l; gr = out_r;
    total++;
    if (out_l !== 16'(el)) begin bad++; $display("FAIL out_l: got %h want %h", out_l, 16'(el)); end
    total++;
    if (out_r !== 16'(er)) begin bad++; $display("FAIL out_r: got %h want %h", out_r, 16'(er)); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_done: got %b want 1", busy); end
    model_peak(el, er);
    tick;
    total++;
    if (out_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL strobe_end: got ready=%b busy=%b want 0 0", out_ready, busy);
    end
    total++;
    if (pan_state !== model_pan_vec()) begin
      bad++; $display("FAIL pan_state: got %h want %h", pan_state, model_pan_vec());
    end
    total++;
    if (peak_l !== 4'(m_pk[0]) || peak_r !== 4'(m_pk[1])) begin
      bad++; $display("FAIL peak: got %h/%h want %h/%h", peak_l, peak_r, 4'(m_pk[0]), 4'(m_pk[1]));
    end
  endtask

  task automatic test_reset;
    reset_n = 0; in_ready = 1; samples_in = {$urandom, $urandom};
    repeat (3) begin
      tick;
      total++;
      if (out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", out_ready); end
    end
    in_ready = 0; reset_n = 1;
    model_reset();
    tick;
    total++;
    if ({out_l, out_r, out_ready, busy, overrun_cnt, pan_state, peak_l, peak_r} !== '0) begin
      bad++;
      $display("FAIL reset_state: got l=%h r=%h rdy=%b busy=%b ovr=%h pan=%h pk=%h/%h want all 0",
               out_l, out_r, out_ready, busy, overrun_cnt, pan_state, peak_l, peak_r);
    end
  endtask

  task automatic test_basic;
    logic [15:0] gl, gr;
    run_frame({16'h0, 16'h0, 16'h0800, 16'h1000}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h1800 || gr !== 16'h1800) begin
      bad++; $display("FAIL basic_sum: got %h/%h want 1800/1800", gl, gr);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] gl, gr;
    run_frame({4{16'h7000}}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h7FFF || gr !== 16'h7FFF) begin
      bad++; $display("FAIL sat_pos: got %h/%h want 7fff/7fff", gl, gr);
    end
    run_frame({4{16'h9000}}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h8000 || gr !== 16'h8000) begin
      bad++; $display("FAIL sat_neg: got %h/%h want 8000/8000", gl, gr);
    end
  endtask

  task automatic test_pan_swap;
    logic [15:0] gl, gr;
    pulse_pan(1);
    total++;
    if (pan_state !== 8'h04) begin bad++; $display("FAIL pan_one: got %h want 04", pan_state); end
    run_frame({16'h0, 16'h0, 16'h0200, 16'h0100}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h0300 || gr !== 16'h0100) begin
      bad++; $display("FAIL pan_mix: got %h/%h want 0300/0100", gl, gr);
    end
    pulse_swap();
    run_frame({16'h0, 16'h0, 16'h0200, 16'h0100}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h0100 || gr !== 16'h0300) begin
      bad++; $display("FAIL swap_mix: got %h/%h want 0100/0300", gl, gr);
    end
    pulse_swap();
    repeat (4) pulse_pan(3);
    total++;
    if (pan_state !== 8'h04) begin bad++; $display("FAIL pan_wrap: got %h want 04", pan_state); end
    repeat (3) pulse_pan(1);
    total++;
    if (pan_state !== 8'h00) begin bad++; $display("FAIL pan_clear: got %h want 00", pan_state); end
  endtask

  task automatic test_att;
    logic [15:0] gl, gr;
    repeat (2) pulse_att();
    run_frame({16'h0, 16'h0, 16'h0, 16'h4000}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h1000 || gr !== 16'h1000) begin
      bad++; $display("FAIL att_pos: got %h/%h want 1000/1000", gl, gr);
    end
    run_frame({16'h0, 16'h0, 16'h0, 16'hFFFC}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'hFFFF || gr !== 16'hFFFF) begin
      bad++; $display("FAIL att_neg: got %h/%h want ffff/ffff", gl, gr);
    end
    repeat (6) pulse_att();
    run_frame({16'h0, 16'h0, 16'h0, 16'h4000}, 0, 0, gl, gr);
    total++;
    if (gl !== 16'h4000) begin bad++; $display("FAIL att_wrap: got %h want 4000", gl); end
  endtask

  task automatic test_peak;
    logic [15:0] gl, gr;
    apply_reset();
    run_frame({16'h0, 16'h0, 16'h0, 16'h4000}, 0, 0, gl, gr);
`ifdef MIXER_PEAK_METER_EN
    total++;
    if (peak_l !== 4'd8) begin bad++; $display("FAIL peak_rise: got %h want 8", peak_l); end
    repeat (4) run_frame('0, 0, 0, gl, gr);
    total++;
    if (peak_l !== 4'd7) begin bad++; $display("FAIL peak_decay: got %h want 7", peak_l); end
`else
    total++;
    if (peak_l !== 4'd0 || peak_r !== 4'd0) begin
      bad++; $display("FAIL peak_off: got %h/%h want 0/0", peak_l, peak_r);
    end
`endif
  endtask

  task automatic test_midframe;
    logic [15:0] gl, gr;
    run_frame({$urandom, $urandom}, 1, 0, gl, gr);
    run_frame({$urandom, $urandom}, 0, 1, gl, gr);
    run_frame({$urandom, $urandom}, 0, 0, gl, gr);
  endtask

  task automatic test_overrun;
    int el, er, cnt;
    logic [63:0] s;
    s = {$urandom, $urandom};
    model_frame(s, el, er);
    samples_in = s; in_ready = 1; tick;
    in_ready = 0; tick;
    in_ready = 1; tick;
    in_ready = 0;
    cnt = 0;
    repeat (12) begin if (out_ready === 1'b1) cnt++; tick; end
    model_peak(el, er);
    total++;
    if (cnt != 1) begin bad++; $display("FAIL ovr_frames: got %0d want 1", cnt); end
    total++;
    if (overrun_cnt !== 8'd1) begin bad++; $display("FAIL ovr_count: got %0d want 1", overrun_cnt); end
    total++;
    if (out_l !== 16'(el) || out_r !== 16'(er)) begin
      bad++; $display("FAIL ovr_out: got %h/%h want %h/%h", out_l, out_r, 16'(el), 16'(er));
    end
    samples_in = {4{16'h1234}}; in_ready = 1; tick;
    in_ready = 0; tick; tick;
    reset_n = 0; tick;
    reset_n = 1;
    model_reset();
    cnt = 0;
    repeat (10) begin if (out_ready === 1'b1) cnt++; tick; end
    total++;
    if (cnt != 0) begin bad++; $display("FAIL abort_frames: got %0d want 0", cnt); end
    total++;
    if (overrun_cnt !== 8'd0 || busy !== 1'b0 || out_l !== 16'h0) begin
      bad++; $display("FAIL abort_state: got ovr=%0d busy=%b l=%h want 0 0 0", overrun_cnt, busy, out_l);
    end
  endtask

  task automatic test_ovr_saturate;
    samples_in = {$urandom, $urandom};
    in_ready = 1;
    repeat (400) tick;
    in_ready = 0;
    repeat (10) tick;
    total++;
    if (overrun_cnt !== 8'hFF) begin bad++; $display("FAIL ovr_hold: got %0d want 255", overrun_cnt); end
    apply_reset();
  endtask

  task automatic test_random;
    logic [15:0] gl, gr;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1)) pulse_pan($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 2) == 0) pulse_att();
      if ($urandom_range(0, 3) == 0) pulse_swap();
      run_frame({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), gl, gr);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] gl, gr;
    for (int it = 0; it < 10; it++) run_frame({$urandom, $urandom}, 0, 0, gl, gr);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_saturate();
    test_pan_swap();
    test_att();
    test_peak();
    test_midframe();
    test_overrun();
    test_ovr_saturate();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
